// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: memory request/response channel, decoder handoff and next-PC return.
// The master modport is the fetch unit; the slave modport is its environment.
interface ifu_fetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int ISA_WIDTH  = 32
);
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_rsp_valid;
    logic [ISA_WIDTH-1:0]  mem_rsp_data;
    logic                  mem_rsp_err;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [ISA_WIDTH-1:0]  inst;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  fetch_err;
    logic                  pc_next_valid;
    logic [ADDR_WIDTH-1:0] pc_next;

    modport master (
        output mem_req_valid, mem_req_addr, inst_valid, inst, pc, fetch_err,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        input  inst_ready, pc_next_valid, pc_next
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, inst_valid, inst, pc, fetch_err,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        output inst_ready, pc_next_valid, pc_next
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: sole PC holder, one outstanding fetch at a time, registered
// {inst, pc, fetch_err} handoff to the decoder, then waits for the next PC.
module ifu_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    ISA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h80000000
) (
    input  logic         clk,
    input  logic         rst,
    ifu_fetch_if.master  fetch_bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_PC
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  req_vld_q, req_vld_d;
    logic                  inst_vld_q, inst_vld_d;
    logic [ISA_WIDTH-1:0]  inst_q, inst_d;
    logic                  err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            req_vld_q  <= 1'b0;
            inst_vld_q <= 1'b0;
            inst_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            req_vld_q  <= req_vld_d;
            inst_vld_q <= inst_vld_d;
            inst_q     <= inst_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        req_vld_d  = req_vld_q;
        inst_vld_d = inst_vld_q;
        inst_d     = inst_q;
        err_d      = err_q;

        unique case (state_q)
            S_IDLE: begin
                addr_d    = pc_q;
                req_vld_d = 1'b1;
                state_d   = S_REQ;
            end
            S_REQ: begin
                if (fetch_bus.mem_req_ready) begin
                    req_vld_d = 1'b0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (fetch_bus.mem_rsp_valid) begin
                    inst_d     = fetch_bus.mem_rsp_data;
                    err_d      = fetch_bus.mem_rsp_err;
                    inst_vld_d = 1'b1;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (fetch_bus.inst_ready) begin
                    inst_vld_d = 1'b0;
                    state_d    = S_PC;
                end
            end
            S_PC: begin
                if (fetch_bus.pc_next_valid) begin
                    pc_d = fetch_bus.pc_next;
                    if (fetch_bus.pc_next[1:0] == 2'b00) begin
                        addr_d    = fetch_bus.pc_next;
                        req_vld_d = 1'b1;
                        state_d   = S_REQ;
                    end else begin
                        // Misaligned target: report the fault directly, never touch memory.
                        inst_d     = '0;
                        err_d      = 1'b1;
                        inst_vld_d = 1'b1;
                        state_d    = S_HOLD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign fetch_bus.mem_req_valid = req_vld_q;
    assign fetch_bus.mem_req_addr  = addr_q;
    assign fetch_bus.inst_valid    = inst_vld_q;
    assign fetch_bus.inst          = inst_q;
    assign fetch_bus.pc            = pc_q;
    assign fetch_bus.fetch_err     = err_q;
endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: reset, stalls, backpressure, redirect, faults, throughput, async reset.
module tb_ifu_fetch;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   hs_cnt;
    int   hs_base;

    ifu_fetch_if #(.ADDR_WIDTH(32), .ISA_WIDTH(32)) bus ();

    ifu_fetch #(.ADDR_WIDTH(32), .ISA_WIDTH(32), .RESET_PC(32'h80000000)) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Request handshakes seen on the bus (pre-edge values).
    initial hs_cnt = 0;
    always @(posedge clk) if (!rst && bus.mem_req_valid && bus.mem_req_ready) hs_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        bus.mem_rsp_err   = 1'b0;
        bus.inst_ready    = 1'b0;
        bus.pc_next_valid = 1'b0;
        bus.pc_next       = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.mem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%b exp=0", bus.mem_req_valid); end
        checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL rst_inst_valid got=%b exp=0", bus.inst_valid); end
        checks++; if (bus.inst !== 32'h0) begin failures++; $display("FAIL rst_inst got=%h exp=00000000", bus.inst); end
        checks++; if (bus.fetch_err !== 1'b0) begin failures++; $display("FAIL rst_fetch_err got=%b exp=0", bus.fetch_err); end
        checks++; if (bus.pc !== 32'h80000000) begin failures++; $display("FAIL rst_pc got=%h exp=80000000", bus.pc); end
        checks++; if (bus.mem_req_addr !== 32'h80000000) begin failures++; $display("FAIL rst_addr got=%h exp=80000000", bus.mem_req_addr); end
        rst = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        checks++; if (bus.mem_req_valid !== 1'b1) begin failures++; $display("FAIL first_req_valid got=%b exp=1", bus.mem_req_valid); end
        checks++; if (bus.mem_req_addr !== 32'h80000000) begin failures++; $display("FAIL first_req_addr got=%h exp=80000000", bus.mem_req_addr); end
    endtask

    task automatic test_basic_fetch();
        tick();  // request accepted
        bus.mem_req_ready = 1'b0;
        checks++; if (bus.mem_req_valid !== 1'b0) begin failures++; $display("FAIL basic_req_drop got=%b exp=0", bus.mem_req_valid); end
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h00000413;
        tick();
        bus.mem_rsp_valid = 1'b0;
        checks++; if (bus.inst_valid !== 1'b1) begin failures++; $display("FAIL basic_inst_valid got=%b exp=1", bus.inst_valid); end
        checks++; if (bus.inst !== 32'h00000413) begin failures++; $display("FAIL basic_inst got=%h exp=00000413", bus.inst); end
        checks++; if (bus.pc !== 32'h80000000) begin failures++; $display("FAIL basic_pc got=%h exp=80000000", bus.pc); end
        checks++; if (bus.fetch_err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", bus.fetch_err); end
    endtask

    task automatic test_mem_stall();
        test_reset();
        bus.mem_req_ready = 1'b0;
        hs_base = hs_cnt;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h80000000) begin
                failures++; $display("FAIL stall_req_hold cyc=%0d got=%b/%h exp=1/80000000", i, bus.mem_req_valid, bus.mem_req_addr);
            end
        end
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.inst_valid !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
                failures++; $display("FAIL stall_wait cyc=%0d got=%b/%b exp=0/0", i, bus.inst_valid, bus.mem_req_valid);
            end
        end
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h12345678;
        tick();
        bus.mem_rsp_valid = 1'b0;
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h12345678) begin
            failures++; $display("FAIL stall_rsp got=%b/%h exp=1/12345678", bus.inst_valid, bus.inst);
        end
        checks++; if (hs_cnt - hs_base !== 1) begin failures++; $display("FAIL stall_handshakes got=%0d exp=1", hs_cnt - hs_base); end
    endtask

    task automatic test_backpressure();
        hs_base = hs_cnt;
        for (int i = 0; i < 4; i++) begin
            bus.mem_rsp_data  = 32'hA5A50000 + i;
            bus.mem_rsp_valid = i[0];
            bus.mem_rsp_err   = 1'b1;
            bus.pc_next_valid = ~i[0];
            bus.pc_next       = 32'h90000000;
            bus.mem_req_ready = 1'b1;
            tick();
            checks++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h12345678 || bus.pc !== 32'h80000000 || bus.fetch_err !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
                failures++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%h/%b/%b exp=1/12345678/80000000/0/0", i, bus.inst_valid, bus.inst, bus.pc, bus.fetch_err, bus.mem_req_valid);
            end
        end
        idle_inputs();
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL bp_consume got=%b exp=0", bus.inst_valid); end
        bus.inst_ready = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        tick();
        tick();
        idle_inputs();
        checks++; if (bus.inst_valid !== 1'b0 || bus.mem_req_valid !== 1'b0 || bus.pc !== 32'h80000000) begin
            failures++; $display("FAIL bp_pc_wait got=%b/%b/%h exp=0/0/80000000", bus.inst_valid, bus.mem_req_valid, bus.pc);
        end
        checks++; if (hs_cnt - hs_base !== 0) begin failures++; $display("FAIL bp_no_req got=%0d exp=0", hs_cnt - hs_base); end
    endtask

    task automatic test_redirect();
        bus.pc_next_valid = 1'b1;
        bus.pc_next       = 32'h80000010;
        tick();
        bus.pc_next_valid = 1'b0;
        checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h80000010) begin
            failures++; $display("FAIL redir_req got=%b/%h exp=1/80000010", bus.mem_req_valid, bus.mem_req_addr);
        end
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hAABBCCDD;
        tick();
        bus.mem_rsp_valid = 1'b0;
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'hAABBCCDD || bus.pc !== 32'h80000010) begin
            failures++; $display("FAIL redir_inst got=%b/%h/%h exp=1/aabbccdd/80000010", bus.inst_valid, bus.inst, bus.pc);
        end
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
    endtask

    task automatic test_faults();
        hs_base = hs_cnt;
        bus.mem_req_ready = 1'b1;
        bus.pc_next_valid = 1'b1;
        bus.pc_next       = 32'h80000006;
        tick();
        bus.pc_next_valid = 1'b0;
        checks++; if (bus.mem_req_valid !== 1'b0 || bus.inst_valid !== 1'b1 || bus.inst !== 32'h0 || bus.fetch_err !== 1'b1 || bus.pc !== 32'h80000006) begin
            failures++; $display("FAIL misalign got=%b/%b/%h/%b/%h exp=0/1/00000000/1/80000006", bus.mem_req_valid, bus.inst_valid, bus.inst, bus.fetch_err, bus.pc);
        end
        tick();
        checks++; if (hs_cnt - hs_base !== 0 || bus.mem_req_valid !== 1'b0) begin
            failures++; $display("FAIL misalign_no_req got=%0d/%b exp=0/0", hs_cnt - hs_base, bus.mem_req_valid);
        end
        bus.mem_req_ready = 1'b0;
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        bus.pc_next_valid = 1'b1;
        bus.pc_next       = 32'hFFFFFFFC;
        tick();
        bus.pc_next_valid = 1'b0;
        checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'hFFFFFFFC) begin
            failures++; $display("FAIL top_addr got=%b/%h exp=1/fffffffc", bus.mem_req_valid, bus.mem_req_addr);
        end
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hDEADBEEF;
        bus.mem_rsp_err   = 1'b1;
        tick();
        idle_inputs();
        checks++; if (bus.inst_valid !== 1'b1 || bus.fetch_err !== 1'b1 || bus.inst !== 32'hDEADBEEF || bus.pc !== 32'hFFFFFFFC) begin
            failures++; $display("FAIL bus_err got=%b/%b/%h/%h exp=1/1/deadbeef/fffffffc", bus.inst_valid, bus.fetch_err, bus.inst, bus.pc);
        end
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h00100093;
        bus.inst_ready    = 1'b1;
        bus.pc_next_valid = 1'b1;
        bus.pc_next       = 32'h80000020;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++; if (bus.inst_valid !== ((k % 4) == 3) || bus.mem_req_valid !== ((k % 4) == 1)) begin
                failures++; $display("FAIL b2b cyc=%0d got=%b/%b exp=%b/%b", k, bus.inst_valid, bus.mem_req_valid, (k % 4) == 3, (k % 4) == 1);
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        bus.pc_next_valid = 1'b1;
        bus.pc_next       = 32'h80000040;
        tick();
        bus.pc_next_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        checks++; if (bus.pc !== 32'h80000040) begin failures++; $display("FAIL ar_pre_pc got=%h exp=80000040", bus.pc); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.mem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0 || bus.pc !== 32'h80000000) begin
            failures++; $display("FAIL ar_immediate got=%b/%b/%h exp=0/0/80000000", bus.mem_req_valid, bus.inst_valid, bus.pc);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h80000000) begin
            failures++; $display("FAIL ar_refetch got=%b/%h exp=1/80000000", bus.mem_req_valid, bus.mem_req_addr);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        hs_base  = 0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        test_basic_fetch();
        test_mem_stall();
        test_backpressure();
        test_redirect();
        test_faults();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
